// File: rtl/dcpu16_marb_if.sv
// One simplified-Wishbone port: master drives adr/stb/wre/dto, slave answers with dti/ack.
// The arbiter uses three slave views (F, G, DMA) and one master view (memory).
interface dcpu16_marb_if #(
    parameter int AW = 16,
    parameter int DW = 16
) ();
    logic [AW-1:0] adr;
    logic          stb;
    logic          wre;
    logic [DW-1:0] dto;
    logic [DW-1:0] dti;
    logic          ack;

    modport master (output adr, output stb, output wre, output dto, input dti, input ack);
    modport slave  (input adr, input stb, input wre, input dto, output dti, output ack);
endinterface

// File: rtl/dcpu16_marb.sv
// Three-way memory arbiter (CPU F-BUS, CPU G-BUS, DMA) onto one simplified-Wishbone memory port.
// Registered grant/address path, one transaction at a time, per-transaction ack timeout.
module dcpu16_marb #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TMO     = 15,
    parameter int PRI_FIX = 0
) (
    input  logic          clk,
    input  logic          rst,
    dcpu16_marb_if.slave  f_bus,
    dcpu16_marb_if.slave  g_bus,
    dcpu16_marb_if.slave  d_bus,
    dcpu16_marb_if.master x_bus,
    output logic          tmo
);
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    localparam logic [1:0] P_F = 2'd0;
    localparam logic [1:0] P_G = 2'd1;
    localparam logic [1:0] P_D = 2'd2;

    localparam int CW = (TMO < 2) ? 1 : $clog2(TMO + 1);
    // Expiry fires in the TMO-th BUSY cycle, so x_stb is high for exactly TMO cycles.
    localparam logic [CW-1:0] CNT_LAST = CW'((TMO == 0) ? 0 : TMO - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    state_t        state_reg;
    logic [1:0]    ptr_reg;
    logic [1:0]    win_reg;
    logic [CW-1:0] cnt_reg;
    logic          x_stb_reg;
    logic          x_wre_reg;
    logic [AW-1:0] x_adr_reg;
    logic [DW-1:0] x_dto_reg;
    logic [2:0]    ack_reg;
    logic [DW-1:0] dti_reg [3];
    logic          tmo_reg;

    logic [2:0]    req;
    logic [1:0]    cand [3];
    logic [1:0]    win;
    logic [AW-1:0] adr_sel;
    logic          wre_sel;
    logic [DW-1:0] dto_sel;

    assign req = {d_bus.stb, g_bus.stb, f_bus.stb};

    // Search order starts just after the last winner; fixed mode always searches F,G,D.
    always_comb begin
        cand[0] = P_F;
        cand[1] = P_G;
        cand[2] = P_D;
        if (PRI_FIX == 0) begin
            case (ptr_reg)
                P_F: begin cand[0] = P_G; cand[1] = P_D; cand[2] = P_F; end
                P_G: begin cand[0] = P_D; cand[1] = P_F; cand[2] = P_G; end
                default: begin cand[0] = P_F; cand[1] = P_G; cand[2] = P_D; end
            endcase
        end
        win = cand[2];
        if (req[cand[1]]) win = cand[1];
        if (req[cand[0]]) win = cand[0];
    end

    always_comb begin
        adr_sel = f_bus.adr;
        wre_sel = f_bus.wre;
        dto_sel = f_bus.dto;
        case (win)
            P_G: begin adr_sel = g_bus.adr; wre_sel = g_bus.wre; dto_sel = g_bus.dto; end
            P_D: begin adr_sel = d_bus.adr; wre_sel = d_bus.wre; dto_sel = d_bus.dto; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            ptr_reg   <= P_D;
            win_reg   <= P_F;
            cnt_reg   <= '0;
            x_stb_reg <= 1'b0;
            x_wre_reg <= 1'b0;
            x_adr_reg <= '0;
            x_dto_reg <= '0;
            ack_reg   <= 3'b000;
            tmo_reg   <= 1'b0;
            for (int i = 0; i < 3; i++) dti_reg[i] <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        win_reg   <= win;
                        x_adr_reg <= adr_sel;
                        x_wre_reg <= wre_sel;
                        x_dto_reg <= dto_sel;
                        x_stb_reg <= 1'b1;
                        cnt_reg   <= '0;
                        if (PRI_FIX == 0) ptr_reg <= win;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    // A memory ack in the expiry cycle takes precedence over the timeout.
                    if (x_bus.ack) begin
                        x_stb_reg <= 1'b0;
                        for (int i = 0; i < 3; i++)
                            if (win_reg == 2'(i)) dti_reg[i] <= x_bus.dti;
                        ack_reg   <= 3'b001 << win_reg;
                        state_reg <= ACK;
                    end else if ((TMO != 0) && (cnt_reg == CNT_LAST)) begin
                        x_stb_reg <= 1'b0;
                        for (int i = 0; i < 3; i++)
                            if (win_reg == 2'(i)) dti_reg[i] <= '1;
                        ack_reg   <= 3'b001 << win_reg;
                        tmo_reg   <= 1'b1;
                        state_reg <= ACK;
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ACK: begin
                    ack_reg   <= 3'b000;
                    tmo_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign x_bus.stb = x_stb_reg;
    assign x_bus.wre = x_wre_reg;
    assign x_bus.adr = x_adr_reg;
    assign x_bus.dto = x_dto_reg;
    assign f_bus.ack = ack_reg[0];
    assign g_bus.ack = ack_reg[1];
    assign d_bus.ack = ack_reg[2];
    assign f_bus.dti = dti_reg[0];
    assign g_bus.dti = dti_reg[1];
    assign d_bus.dti = dti_reg[2];
    assign tmo       = tmo_reg;
endmodule
